helix_pb_sequencer: RTL and testbench

Bring-up and step controller for the Helix PicoBlaze setup engine. On request it resets the PicoBlaze core and the system-reset handshake, then waits for the firmware to report reset complete. It then issues a programmed number of single-step commands, each acknowledged by the firmware's control-port write, with a timeout on every wait. It sits beside the PicoBlaze wrapper, drives that wrapper's `rst_i`, `sys_rst_i` and `step_i`, and snoops its output port bus.

---
 rtl/helix_seq_pkg.sv | 17 +
 rtl/helix_seq_timer.sv | 19 +
 rtl/helix_pb_sequencer.sv | 116 +++++++++++
 tb/tb_helix_pb_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/helix_seq_pkg.sv
// helix_seq_pkg: shared state encoding and error codes for the PicoBlaze sequencer
package helix_seq_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PBRST,
    WAIT_RST,
    STEP_ISSUE,
    STEP_WAIT,
    STEP_GAP,
    DONE,
    ERROR
  } state_t;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RST_TO   = 2'd1;
  localparam logic [1:0] ERR_STEP_TO  = 2'd2;
  localparam logic [1:0] ERR_RST_LOST = 2'd3;
endpackage

// File: rtl/helix_seq_timer.sv
// helix_seq_timer: loadable down-counter whose load cycle already counts as the first timed cycle
module helix_seq_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;
  // count down to zero and hold; a load restarts from value minus the current cycle
  always_ff @(posedge clk) begin
    if (clear) cnt <= '0;
    else if (load) cnt <= value - W'(value != '0);
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign expired = load ? value == '0 : cnt == '0;
endmodule

// File: rtl/helix_pb_sequencer.sv
// helix_pb_sequencer: PicoBlaze bring-up, reset handshake and single-step controller
module helix_pb_sequencer
  import helix_seq_pkg::*;
#(
  parameter int PB_RESET_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int STEP_GAP_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] nsteps_i,
  output logic       pb_rst_o,
  output logic       sys_rst_o,
  input  logic       sys_rst_complete_i,
  output logic       step_o,
  input  logic [7:0] pb_port_id_i,
  input  logic [7:0] pb_out_port_i,
  input  logic       pb_write_strobe_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [1:0] err_code_o,
  output logic [7:0] step_count_o
);
  localparam int M1 = PB_RESET_CYCLES > STEP_GAP_CYCLES ? PB_RESET_CYCLES : STEP_GAP_CYCLES;
  localparam int W  = $clog2((TIMEOUT_CYCLES > M1 ? TIMEOUT_CYCLES : M1) + 1);
  state_t state, prev;
  logic [7:0] nsteps;
  logic [W-1:0] dur;
  logic entry, expired, ack, unused_bits;
  assign ack = pb_port_id_i[7] & pb_write_strobe_i & pb_out_port_i[0];
  assign unused_bits = ^{pb_port_id_i[6:0], pb_out_port_i[7:1]};
  assign entry = state != prev;
  // length of the state just entered, reloaded into the shared timer on every state change
  always_comb
    dur = state == PBRST ? W'(PB_RESET_CYCLES - 1) :
          (state == WAIT_RST || state == STEP_WAIT) ? W'(TIMEOUT_CYCLES - 1) :
          state == STEP_GAP ? W'(STEP_GAP_CYCLES - 1) : '0;
  helix_seq_timer #(.W(W)) timer (
    .clk    (clk_i),
    .clear  (rst_i),
    .load   (entry),
    .value  (dur),
    .expired(expired)
  );
  // sequencer; every output is registered alongside the state it belongs to
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      prev         <= IDLE;
      nsteps       <= '0;
      pb_rst_o     <= 1'b0;
      sys_rst_o    <= 1'b0;
      step_o       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      err_code_o   <= ERR_NONE;
      step_count_o <= '0;
    end else begin
      prev   <= state;
      done_o <= 1'b0;
      step_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state        <= PBRST;
          pb_rst_o     <= 1'b1;
          sys_rst_o    <= 1'b1;
          busy_o       <= 1'b1;
          error_o      <= 1'b0;
          err_code_o   <= ERR_NONE;
          step_count_o <= '0;
          nsteps       <= nsteps_i;
        end
        PBRST: if (expired) begin
          state     <= WAIT_RST;
          pb_rst_o  <= 1'b0;
          sys_rst_o <= 1'b0;
        end
        WAIT_RST:
          if (sys_rst_complete_i) begin
            state  <= nsteps == '0 ? DONE : STEP_ISSUE;
            done_o <= nsteps == '0;
            step_o <= nsteps != '0;
          end else if (expired) begin
            state      <= ERROR;
            error_o    <= 1'b1;
            err_code_o <= ERR_RST_TO;
          end
        STEP_ISSUE, STEP_WAIT, STEP_GAP:
          if (!sys_rst_complete_i) begin
            state      <= ERROR;
            error_o    <= 1'b1;
            err_code_o <= ERR_RST_LOST;
          end else if (state == STEP_ISSUE) state <= STEP_WAIT;
          else if (state == STEP_WAIT && ack) begin
            state        <= STEP_GAP;
            step_count_o <= step_count_o + 8'(step_count_o != 8'hff);
          end else if (state == STEP_WAIT && expired) begin
            state      <= ERROR;
            error_o    <= 1'b1;
            err_code_o <= ERR_STEP_TO;
          end else if (state == STEP_GAP && expired) begin
            state  <= step_count_o == nsteps ? DONE : STEP_ISSUE;
            done_o <= step_count_o == nsteps;
            step_o <= step_count_o != nsteps;
          end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_helix_pb_sequencer.sv
// tb_helix_pb_sequencer: scoreboard bench predicting whole-sequence outcomes from firmware behaviour
module tb_helix_pb_sequencer;
  localparam int PBR = 16, TO = 64, GAP = 2;
  typedef struct { int n; int cd; int a; int hold; int drop; bit noise; } scn_t;
  typedef struct { int busy; int pbr; int pulses; int done; int err; int code; int count; } exp_t;
  logic clk = 0, rst_i = 1, start_i = 0, cmp = 0, wstb = 0;
  logic [7:0] nsteps_i = 0, pid = 0, pout = 0;
  logic pb_rst_o, sys_rst_o, step_o, busy_o, done_o, error_o;
  logic [1:0] err_code_o;
  logic [7:0] step_count_o;
  int n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  scn_t cur;
  bit abort = 0, hung = 0;
  int e_rc, e_wc, e_sidx;
  bit e_rs, e_live, e_post, e_ack;
  int m_busy = 0, m_pbr = 0, m_sys = 0, m_rise = 0, m_done = 0;
  bit m_pbusy = 0, m_pstep = 0;

  helix_pb_sequencer #(.PB_RESET_CYCLES(PBR), .TIMEOUT_CYCLES(TO), .STEP_GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .nsteps_i(nsteps_i),
    .pb_rst_o(pb_rst_o), .sys_rst_o(sys_rst_o), .sys_rst_complete_i(cmp), .step_o(step_o),
    .pb_port_id_i(pid), .pb_out_port_i(pout), .pb_write_strobe_i(wstb),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .step_count_o(step_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic scn_t mk(int n, int cd, int a, int hold, int drop, bit noise);
    scn_t s;
    s.n = n; s.cd = cd; s.a = a; s.hold = hold; s.drop = drop; s.noise = noise;
    return s;
  endfunction

  // outcome of one sequence from the firmware behaviour: cd = reset-complete delay into
  // the wait (negative = never), a = ack delay after each step pulse
  function automatic exp_t model(scn_t s);
    exp_t e;
    e = '{busy: 0, pbr: PBR, pulses: 0, done: 0, err: 0, code: 0, count: 0};
    if (s.cd < 0 || s.cd >= TO) begin
      e.err = 1; e.code = 1; e.busy = PBR + TO + 1;
      return e;
    end
    e.busy = PBR + s.cd + 2;
    for (int i = 0; i < s.n; i++) begin
      e.pulses++;
      if (i == s.hold || s.a >= TO) begin
        e.err = 1; e.code = 2; e.busy += 1 + TO;
        return e;
      end
      if (i == s.drop) begin
        e.err = 1; e.code = 3; e.busy += s.a + 2;
        return e;
      end
      e.count++;
      e.busy += s.a + 2 + GAP;
    end
    e.done = 1;
    return e;
  endfunction

  // firmware / wrapper emulation driven on the falling edge
  initial begin
    e_rc = 0; e_wc = 0; e_sidx = -1; e_rs = 0; e_live = 0; e_post = 0;
    forever begin
      @(negedge clk);
      e_ack = 0;
      if (e_post) begin e_ack = cur.noise; e_post = 0; end
      if (rst_i) begin e_live = 0; e_rs = 0; end
      if (sys_rst_o) begin
        cmp = 0; e_rs = 1; e_rc = 0; e_sidx = -1; e_live = 0;
      end else if (e_rs) begin
        if (e_rc == cur.cd) cmp = 1;
        e_rc++;
      end
      if (step_o) begin
        e_sidx++; e_wc = 0; e_live = 1; e_ack = e_ack | cur.noise;
      end else if (e_live) begin
        if (e_wc == cur.a && e_sidx != cur.hold) begin
          e_ack = 1; e_live = 0; e_post = 1;
          if (e_sidx == cur.drop) cmp = 0;
        end
        e_wc++;
      end
      if (e_ack) begin
        pid = {1'b1, 7'($urandom)}; pout = {7'($urandom), 1'b1}; wstb = 1;
      end else begin
        pid = 8'($urandom); pout = 8'($urandom); wstb = 1'($urandom);
        if (pid[7] & pout[0]) wstb = 0;
      end
    end
  end

  // monitor: accumulate per-sequence observations and score them when busy_o falls
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy_o) begin
        m_busy++;
        m_pbr += int'(pb_rst_o);
        m_sys += int'(sys_rst_o);
      end
      if (step_o && !m_pstep) m_rise++;
      m_done += int'(done_o);
      if (m_pbusy && !busy_o) begin
        if (abort) abort = 0;
        else begin
          check("exp_queued", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy_cycles", m_busy, e.busy);
            check("pb_rst_cycles", m_pbr, e.pbr);
            check("sys_rst_cycles", m_sys, e.pbr);
            check("step_pulses", m_rise, e.pulses);
            check("done_pulses", m_done, e.done);
            check("error_o", int'(error_o), e.err);
            check("err_code_o", int'(err_code_o), e.code);
            check("step_count_o", int'(step_count_o), e.count);
          end
        end
        m_busy = 0; m_pbr = 0; m_sys = 0; m_rise = 0; m_done = 0;
      end
      m_pbusy = busy_o;
      m_pstep = step_o;
    end
  end

  task automatic run(scn_t s);
    int k;
    if (hung) return;
    cur = s;
    nsteps_i = 8'(s.n);
    exp_q.push_back(model(s));
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    repeat (9) @(negedge clk);
    start_i = 1;
    nsteps_i = 8'($urandom);
    @(negedge clk);
    start_i = 0;
    k = 0;
    while (busy_o && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (busy_o) begin
      n_cmp++; n_bad++; hung = 1;
      $display("FAIL seq_hang: busy_o still 1 after %0d cycles, expected 0", k);
    end
    @(negedge clk);
  endtask

  task automatic outputs_zero(string tag);
    check({tag, "_pb_rst"}, int'(pb_rst_o), 0);
    check({tag, "_sys_rst"}, int'(sys_rst_o), 0);
    check({tag, "_step"}, int'(step_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_error"}, int'(error_o), 0);
    check({tag, "_err_code"}, int'(err_code_o), 0);
    check({tag, "_count"}, int'(step_count_o), 0);
  endtask

  initial begin
    int k;
    cur = mk(0, -1, 0, -1, -1, 0);
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    rst_i = 0;
    @(negedge clk);
    run(mk(2, -1, 0, -1, -1, 0));
    run(mk(3, 2, 5, -1, -1, 0));
    run(mk(0, 4, 0, -1, -1, 0));
    run(mk(2, 3, 4, 1, -1, 0));
    run(mk(3, 1, 2, -1, 1, 1));
    run(mk(4, 63, 63, -1, -1, 1));
    run(mk(1, 64, 0, -1, -1, 0));
    run(mk(1, 0, 64, -1, -1, 0));
    run(mk(255, 0, 0, -1, -1, 1));
    if (!hung) begin
      cur = mk(2, 2, 0, 0, -1, 0);
      nsteps_i = 2;
      abort = 1;
      start_i = 1;
      @(negedge clk);
      start_i = 0;
      k = 0;
      while (!step_o && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("abort_step_seen", int'(step_o), 1);
      repeat (3) @(negedge clk);
      rst_i = 1;
      @(negedge clk);
      rst_i = 0;
      outputs_zero("midrst");
      @(negedge clk);
      abort = 0;
      run(mk(2, 1, 3, -1, -1, 1));
    end
    for (int i = 0; i < 25; i++) begin
      int n, cd, a, hold, drop;
      n = $urandom_range(0, 6);
      cd = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 15);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 66) : $urandom_range(0, 10);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      drop = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      run(mk(n, cd, a, hold, drop, 1'($urandom)));
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
